multi_timer_irq: RTL and testbench
==================================

Name: multi_timer_irq

Overview:
- Parametrised, memory-mapped interrupt source for the pipelined MIPS CPU; the successor of the fixed single-source interrupt stimulus.
- Holds N_CH independent down-counter channels, each programmable as one-shot or auto-reload.
- Produces a per-channel pending vector and one aggregated interrupt line that drives the CPU interrupt input.
- Sits on the CPU's device bus beside the data memory, decoded by the system bridge.

Parameters:
- N_CH, 2, number of timer channels (1..8).
- CNT_W, 32, counter and preset width in bits.
- ADDR_W, 8, byte-address width of the local register window; channel c occupies offset c*16.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- addr  input  ADDR_W  byte address, word-aligned; bits 1:0 ignored.
- we  input  1  write strobe, sampled on the rising clk edge.
- wdata  input  32  write data.
- rdata  output  32  combinational read data for addr.
- irq_vec  output  N_CH  per-channel pending AND mask.
- irq  output  1  OR-reduction of irq_vec, to the CPU interrupt input.

Behaviour:
- Register map per channel, base c*16:
  - 0x0 CTRL (RW): bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1 = enabled), all other bits read 0.
  - 0x4 PRESET (RW), CNT_W bits, zero-extended on read.
  - 0x8 COUNT (RO; writes ignored).
  - 0xC STATUS: bit0 PEND on read; writing any value clears PEND.
- Unmapped offsets and channels >= N_CH read 0; writes to them have no effect.
- Reset (asynchronous): CTRL, PRESET, COUNT = 0; PEND = 0; state = IDLE; irq_vec = 0; irq = 0.
- Per-channel FSM:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT: if EN=0, hold COUNT and state (pause). Else if COUNT > 1, decrement COUNT. Else COUNT <= 0, PEND <= 1, go to INT.
  - INT, MODE=00: clear EN, go to IDLE; PEND stays set until STATUS is written or CTRL is written.
  - INT, MODE=01: go to LOAD; PEND stays set until cleared, so a re-expiry with PEND still set is coalesced.
- Latency: with the CTRL write (EN=1) sampled at edge 0, PEND rises at edge max(PRESET,1)+2; irq is visible the cycle after that edge when IM=1.
- PRESET = 0 behaves as PRESET = 1.
- A CTRL write in any state clears PEND and sends the FSM to IDLE.
  - If the written EN = 1, the channel therefore reloads and restarts next cycle.
  - The bus write wins over the same-cycle FSM update.
- PRESET write while counting: takes effect at the next LOAD only.
- STATUS clear in the same cycle as expiry: the set wins (PEND = 1).
- irq_vec[c] = PEND[c] & IM[c]; irq = |irq_vec. Both are registered-state derived, glitch-free, and have no combinational path from addr/we.
- Reset asserted mid-count: immediate return to reset values, regardless of clk.

Decomposition:
- Shared package multi_timer_pkg:
  - state encoding (IDLE, LOAD, CNT, INT);
  - MODE constants;
  - register offsets (CTRL, PRESET, COUNT, STATUS);
  - CTRL bit indices.
- One sub-module, timer_channel: FSM plus COUNT/PRESET/CTRL/PEND for a single channel.
- Top level: generates N_CH instances, decodes addr into per-channel write enables, muxes rdata, and OR-reduces irq.

Test Plan:
- Reset with irq checks: reset high 20 ns then low -> all reads return 0; irq = 0; COUNT = 0 for every channel.
- One-shot expiry: ch0 PRESET = 5, CTRL = 0x9 (EN, one-shot, IM) at edge 0 -> PEND rises at edge 7; CTRL reads 0x8; irq stays 1 until STATUS is written at a later edge, then 0.
- Auto-reload coalescing: ch1 PRESET = 3, CTRL = 0xB -> PEND sets at edge 5 and stays set; after a STATUS clear at edge 6, PEND sets again at edge 10.
- Masking and channel independence: ch0 CTRL = 0x1 (IM = 0) with PRESET = 2, ch1 CTRL = 0x9 with PRESET = 4 -> ch0 PEND = 1 but irq_vec = 2'b10; irq tracks ch1 only.
- Pause and PRESET-write boundaries: ch0 counting with COUNT = 3, write CTRL EN = 0 -> COUNT holds 3; rewrite EN = 1 -> reload from PRESET. A PRESET write mid-count leaves the current COUNT unchanged.
- Simultaneous events: STATUS clear on the expiry edge -> PEND = 1. Async reset pulse mid-count -> COUNT = 0 and irq = 0 without a clk edge.

Source files
------------

// File: rtl/multi_timer_irq_pkg.sv
// Shared definitions for the multi-channel interrupt timer.
//   - per-channel FSM state encoding
//   - CTRL.MODE encodings
//   - byte offsets of the four registers inside a 16-byte channel window
//   - CTRL bit positions
package multi_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // MODE = 1x is not a distinct mode; it behaves like one-shot.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Byte offsets within a channel window (address bits 3:0, bits 1:0 forced to 0).
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_PRESET = 4'h4;
  localparam logic [3:0] REG_COUNT  = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'hC;

  // CTRL bit indices.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/multi_timer_irq_if.sv
// Device-bus connection of the interrupt timer.
//   master: drives addr / we / wdata (CPU side, system bridge)
//   slave : returns combinational rdata plus the interrupt outputs
//   addr    ADDR_W byte address (bits 1:0 ignored)
//   we      write strobe, sampled on rising clk
//   wdata   32-bit write data
//   rdata   32-bit read data for addr
//   irq_vec per-channel pending AND mask
//   irq     OR of irq_vec
interface multi_timer_irq_if #(
  parameter int ADDR_W = 8,
  parameter int N_CH   = 2
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [N_CH-1:0]   irq_vec;
  logic              irq;

  modport master (output addr, we, wdata, input rdata, irq_vec, irq);
  modport slave  (input addr, we, wdata, output rdata, irq_vec, irq);
endinterface

// File: rtl/multi_timer_irq_channel.sv
// One down-counter timer channel: CTRL/PRESET/COUNT/PEND registers and FSM.
//   clk, reset            clock, asynchronous active-high reset
//   wr_ctrl/preset/status decoded single-cycle write strobes for this channel
//   wdata                 bus write data
//   ctrl_rd/preset_rd/
//   count_rd              zero-extended register read values
//   pend                  pending flag
//   irq_out               pend AND interrupt mask (flop-derived only)
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_ctrl,
  input  logic        wr_preset,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] preset_rd,
  output logic [31:0] count_rd,
  output logic        pend,
  output logic        irq_out
);

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic               en_q,     en_d;
  logic [1:0]         mode_q,   mode_d;
  logic               im_q,     im_d;
  logic               pend_q,   pend_d;

  // Upper write-data bits are only meaningful for some registers.
  logic [31:0] unused_wdata;
  assign unused_wdata = wdata;

  always_comb begin
    // NOTE: every signal gets a hold default before any branch so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    pend_d   = pend_q;

    // Clear is applied before the FSM so an expiry in the same cycle wins.
    if (wr_status) pend_d = 1'b0;

    unique case (state_q)
      ST_IDLE: if (en_q) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (en_q) begin
          // COUNT <= 1 also covers PRESET = 0, which then acts like 1.
          if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            count_d = '0;
            pend_d  = 1'b1;
            state_d = ST_INT;
          end
        end
      end
      ST_INT: begin
        if (is_reload(mode_q)) begin
          state_d = ST_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Takes effect at the next LOAD only; the running count is untouched.
    if (wr_preset) preset_d = wdata[CNT_W-1:0];

    // A CTRL write overrides every FSM update of this cycle and restarts
    // the channel from IDLE (reloading next cycle when EN is written as 1).
    if (wr_ctrl) begin
      en_d    = wdata[CTRL_EN];
      mode_d  = wdata[CTRL_MODE_HI:CTRL_MODE_LO];
      im_d    = wdata[CTRL_IM];
      pend_d  = 1'b0;
      count_d = count_q;
      state_d = ST_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the same pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      preset_q <= '0;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      preset_q <= preset_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
    end
  end

  assign ctrl_rd   = {28'd0, im_q, mode_q, en_q};
  assign preset_rd = 32'(preset_q);
  assign count_rd  = 32'(count_q);
  assign pend      = pend_q;
  assign irq_out   = pend_q & im_q;

endmodule

// File: rtl/multi_timer_irq.sv
// Memory-mapped multi-channel interrupt timer for the MIPS device bus.
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    slave port: addr/we/wdata in, rdata/irq_vec/irq out
// Channel c occupies byte offsets c*16 .. c*16+15 of the local window.
module multi_timer_irq
  import multi_timer_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  multi_timer_irq_if.slave    bus
);

  localparam int CH_W = ADDR_W - 4;

  logic [CH_W-1:0] ch_idx;
  logic [3:0]      reg_off;
  logic [1:0]      unused_addr_lsb;

  assign ch_idx          = bus.addr[ADDR_W-1:4];
  assign reg_off         = {bus.addr[3:2], 2'b00};
  assign unused_addr_lsb = bus.addr[1:0];

  logic [N_CH-1:0] ch_hit;
  logic [N_CH-1:0] irq_ch;
  logic [N_CH-1:0] pend_ch;
  logic [31:0]     ctrl_rd   [N_CH];
  logic [31:0]     preset_rd [N_CH];
  logic [31:0]     count_rd  [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign ch_hit[c] = (ch_idx == CH_W'(c));

    timer_channel #(.CNT_W(CNT_W)) u_channel (
      .clk       (clk),
      .reset     (reset),
      .wr_ctrl   (bus.we && ch_hit[c] && (reg_off == REG_CTRL)),
      .wr_preset (bus.we && ch_hit[c] && (reg_off == REG_PRESET)),
      .wr_status (bus.we && ch_hit[c] && (reg_off == REG_STATUS)),
      .wdata     (bus.wdata),
      .ctrl_rd   (ctrl_rd[c]),
      .preset_rd (preset_rd[c]),
      .count_rd  (count_rd[c]),
      .pend      (pend_ch[c]),
      .irq_out   (irq_ch[c])
    );
  end

  // Channels beyond N_CH never hit, so their window reads as zero.
  always_comb begin
    bus.rdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_hit[c]) begin
        unique case (reg_off)
          REG_CTRL:   bus.rdata = ctrl_rd[c];
          REG_PRESET: bus.rdata = preset_rd[c];
          REG_COUNT:  bus.rdata = count_rd[c];
          REG_STATUS: bus.rdata = {31'd0, pend_ch[c]};
          default:    bus.rdata = '0;
        endcase
      end
    end
  end

  // Purely flop-derived: no path from addr/we reaches the interrupt outputs.
  assign bus.irq_vec = irq_ch;
  assign bus.irq     = |irq_ch;

endmodule

// File: tb/tb_multi_timer_irq.sv
module tb_multi_timer_irq;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  multi_timer_irq_if #(.ADDR_W(8), .N_CH(2)) bus_if ();

  multi_timer_irq #(.N_CH(2), .CNT_W(32), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write lands on the next rising edge; returns 1 ns after that edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.we    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.we    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus_if.addr = a;
    #1;
    d = bus_if.rdata;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    bus_if.we = 1'b0;
    bus_if.addr = '0;
    bus_if.wdata = '0;
    #20;
    reset = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 4; r++) begin
        logic [7:0] a;
        a = 8'(c * 16 + r * 4);
        rd(a, d);
        total++;
        if (d !== 32'd0) begin
          bad++;
          $display("FAIL reset_read addr=%02h got=%08h exp=00000000", a, d);
        end
      end
    end
    total++;
    if (bus_if.irq !== 1'b0 || bus_if.irq_vec !== 2'b00) begin
      bad++;
      $display("FAIL reset_irq got irq=%b vec=%b exp irq=0 vec=00", bus_if.irq, bus_if.irq_vec);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    do_reset();
    wr(8'h20, 32'h9);
    wr(8'h24, 32'h55);
    rd(8'h20, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL unmapped_ch2 got=%08h exp=00000000", d); end
    wr(8'h08, 32'h1234);
    rd(8'h08, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL count_ro got=%08h exp=00000000", d); end
    wr(8'h00, 32'hFFFF_FFF6);
    rd(8'h00, d);
    total++;
    if (d !== 32'h6) begin bad++; $display("FAIL ctrl_bits got=%08h exp=00000006", d); end
    wr(8'h00, 32'h0);
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    do_reset();
    wr(8'h04, 32'd5);
    wr(8'h00, 32'h9);          // edge 0
    tick(6);                   // edge 6
    rd(8'h0C, d);
    total++;
    if (d !== 32'd0 || bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL oneshot_early pend=%0d irq=%b exp pend=0 irq=0", d, bus_if.irq);
    end
    tick(1);                   // edge 7
    rd(8'h0C, d);
    total++;
    if (d !== 32'd1 || bus_if.irq !== 1'b1 || bus_if.irq_vec !== 2'b01) begin
      bad++; $display("FAIL oneshot_expiry pend=%0d irq=%b vec=%b exp pend=1 irq=1 vec=01", d, bus_if.irq, bus_if.irq_vec);
    end
    tick(1);                   // edge 8
    rd(8'h00, d);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL oneshot_ctrl got=%08h exp=00000008", d); end
    tick(3);
    total++;
    if (bus_if.irq !== 1'b1) begin bad++; $display("FAIL oneshot_hold irq=%b exp=1", bus_if.irq); end
    wr(8'h0C, 32'h0);
    rd(8'h0C, d);
    total++;
    if (d !== 32'd0 || bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL oneshot_clear pend=%0d irq=%b exp pend=0 irq=0", d, bus_if.irq);
    end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    do_reset();
    wr(8'h14, 32'd3);
    wr(8'h10, 32'hB);          // edge 0
    tick(4);                   // edge 4
    rd(8'h1C, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reload_early pend=%0d exp=0", d); end
    tick(1);                   // edge 5
    rd(8'h1C, d);
    total++;
    if (d !== 32'd1 || bus_if.irq_vec !== 2'b10) begin
      bad++; $display("FAIL reload_first pend=%0d vec=%b exp pend=1 vec=10", d, bus_if.irq_vec);
    end
    wr(8'h1C, 32'h0);          // edge 6
    rd(8'h1C, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reload_clear pend=%0d exp=0", d); end
    rd(8'h18, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reload_load_count got=%0d exp=0", d); end
    tick(1);                   // edge 7
    rd(8'h18, d);
    total++;
    if (d !== 32'd3) begin bad++; $display("FAIL reload_count got=%0d exp=3", d); end
    tick(2);                   // edge 9
    rd(8'h1C, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reload_second_early pend=%0d exp=0", d); end
    tick(1);                   // edge 10
    rd(8'h1C, d);
    total++;
    if (d !== 32'd1 || bus_if.irq !== 1'b1) begin
      bad++; $display("FAIL reload_second pend=%0d irq=%b exp pend=1 irq=1", d, bus_if.irq);
    end
    wr(8'h10, 32'h0);
    total++;
    if (bus_if.irq !== 1'b0) begin bad++; $display("FAIL reload_ctrl_clear irq=%b exp=0", bus_if.irq); end
  endtask

  task automatic test_masking();
    logic [31:0] d;
    do_reset();
    wr(8'h04, 32'd2);
    wr(8'h14, 32'd4);
    wr(8'h00, 32'h1);          // edge A
    wr(8'h10, 32'h9);          // edge A+1
    tick(3);                   // edge A+4
    rd(8'h0C, d);
    total++;
    if (d !== 32'd1 || bus_if.irq_vec !== 2'b00 || bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL mask_ch0 pend=%0d vec=%b irq=%b exp pend=1 vec=00 irq=0", d, bus_if.irq_vec, bus_if.irq);
    end
    tick(2);                   // edge A+6
    total++;
    if (bus_if.irq !== 1'b0) begin bad++; $display("FAIL mask_ch1_early irq=%b exp=0", bus_if.irq); end
    tick(1);                   // edge A+7
    total++;
    if (bus_if.irq_vec !== 2'b10 || bus_if.irq !== 1'b1) begin
      bad++; $display("FAIL mask_ch1 vec=%b irq=%b exp vec=10 irq=1", bus_if.irq_vec, bus_if.irq);
    end
  endtask

  task automatic test_pause_preset();
    logic [31:0] d;
    do_reset();
    wr(8'h04, 32'd10);
    wr(8'h00, 32'h1);          // edge 0; COUNT at edge k = 12-k
    tick(9);                   // edge 9
    rd(8'h08, d);
    total++;
    if (d !== 32'd3) begin bad++; $display("FAIL pause_pre got=%0d exp=3", d); end
    wr(8'h00, 32'h0);          // edge 10: bus write wins
    tick(3);
    rd(8'h08, d);
    total++;
    if (d !== 32'd3) begin bad++; $display("FAIL pause_hold got=%0d exp=3", d); end
    wr(8'h04, 32'd7);
    wr(8'h00, 32'h1);          // edge B
    tick(2);                   // edge B+2: LOAD done
    rd(8'h08, d);
    total++;
    if (d !== 32'd7) begin bad++; $display("FAIL pause_reload got=%0d exp=7", d); end
    wr(8'h04, 32'd20);         // edge B+3: count 7 -> 6
    rd(8'h08, d);
    total++;
    if (d !== 32'd6) begin bad++; $display("FAIL preset_midcount got=%0d exp=6", d); end
    rd(8'h04, d);
    total++;
    if (d !== 32'd20) begin bad++; $display("FAIL preset_read got=%0d exp=20", d); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    do_reset();
    wr(8'h04, 32'd3);
    wr(8'h00, 32'h9);          // edge 0
    tick(4);                   // edge 4
    rd(8'h0C, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL sim_early pend=%0d exp=0", d); end
    wr(8'h0C, 32'h0);          // edge 5 = expiry edge
    rd(8'h0C, d);
    total++;
    if (d !== 32'd1 || bus_if.irq !== 1'b1) begin
      bad++; $display("FAIL sim_set_wins pend=%0d irq=%b exp pend=1 irq=1", d, bus_if.irq);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset();
    wr(8'h04, 32'd2);
    wr(8'h00, 32'hB);          // edge 0; PEND at 4, reload COUNT=2 at 6
    tick(6);
    rd(8'h08, d);
    total++;
    if (d !== 32'd2 || bus_if.irq !== 1'b1) begin
      bad++; $display("FAIL areset_pre count=%0d irq=%b exp count=2 irq=1", d, bus_if.irq);
    end
    #1;
    reset = 1'b1;              // mid high phase, no clk edge follows before checks
    rd(8'h08, d);
    total++;
    if (d !== 32'd0 || bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL areset_now count=%0d irq=%b exp count=0 irq=0", d, bus_if.irq);
    end
    rd(8'h00, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL areset_ctrl got=%08h exp=00000000", d); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unmapped();
    test_one_shot();
    test_auto_reload();
    test_masking();
    test_pause_preset();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
